uart_frame_arbiter: RTL and testbench

UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

---
 rtl/uart_frame_pkg.sv | 14 +
 rtl/uart_frame_arbiter_rr_select.sv | 28 ++
 rtl/uart_frame_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_frame_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame arbiter: framing bytes and the
// arbiter state encoding.
package uart_frame_pkg;

   localparam logic [7:0] START_BYTE = 8'hAA;
   localparam logic [7:0] END_BYTE   = 8'hBB;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/uart_frame_arbiter_rr_select.sv
// Combinational round-robin selector: finds the first set request bit
// starting at ptr and wrapping from N-1 back to 0.
module rr_select
   import uart_frame_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   localparam int IW = $clog2(N);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         automatic int cand = (int'(ptr) + i) % N;
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Arbitrates payloads from NREQ requesters onto one UART framer, holding off
// the next grant until the framer has written the whole frame or gone quiet.
module uart_frame_arbiter
   import uart_frame_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int NBYTES         = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ*8*NBYTES-1:0]   req_data_i,
   input  logic [NREQ-1:0]            req_valid_i,
   output logic [NREQ-1:0]            req_ready_o,
   input  logic [NREQ-1:0]            req_mask_i,
   output logic [8*NBYTES-1:0]        frame_data_o,
   output logic                       frame_valid_o,
   output logic [$clog2(NREQ)-1:0]    frame_src_o,
   input  logic                       uart_wr_en_i,
   output logic                       busy_o,
   output logic                       timeout_o
);

   localparam int SW  = $clog2(NREQ);
   localparam int DW  = 8 * NBYTES;
   localparam int WCW = $clog2(NBYTES + 3);
   localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);

   // A frame is start byte + payload + end byte, so NBYTES+2 writes in total.
   localparam logic [WCW-1:0] WR_LAST   = WCW'(NBYTES + 1);
   localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0]  IDX_LAST  = SW'(NREQ - 1);

   arb_state_t     state;
   arb_state_t     state_next;
   logic [SW-1:0]  ptr;
   logic [SW-1:0]  win;
   logic           found;
   logic [NREQ-1:0] eligible;
   logic [WCW-1:0] wr_cnt;
   logic [ICW-1:0] idle_cnt;
   logic           grant;
   logic           frame_done;
   logic           idle_expired;

   assign eligible = req_valid_i & req_mask_i;

   rr_select #(
      .N(NREQ)
   ) u_rr_select (
      .req   (eligible),
      .ptr   (ptr),
      .idx   (win),
      .found (found)
   );

   // Completion and timeout fire on the cycle that makes the count final,
   // so ARB is entered directly on the following cycle.
   assign grant        = (state == ARB) && found;
   assign frame_done   = (state == WAIT) && uart_wr_en_i && (wr_cnt == WR_LAST);
   assign idle_expired = (state == WAIT) && !uart_wr_en_i && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ARB: begin
            if (grant) begin
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (frame_done || idle_expired) begin
               state_next = ARB;
            end
         end
         default: begin
            state_next = ARB;
         end
      endcase
   end

   // Reset wins over a same-cycle grant, so handshake outputs are gated by rst.
   always_comb begin
      req_ready_o   = '0;
      frame_valid_o = 1'b0;
      busy_o        = (state != ARB);
      if (!rst) begin
         if (grant) begin
            req_ready_o[win] = 1'b1;
         end
         frame_valid_o = (state == LAUNCH);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= '0;
         frame_data_o <= '0;
         frame_src_o  <= '0;
         wr_cnt       <= '0;
         idle_cnt     <= '0;
         timeout_o    <= 1'b0;
      end else begin
         if (grant) begin
            frame_data_o <= req_data_i[win*DW +: DW];
            frame_src_o  <= win;
            ptr          <= (win == IDX_LAST) ? '0 : win + 1'b1;
         end
         if (state == WAIT) begin
            if (uart_wr_en_i) begin
               idle_cnt <= '0;
               wr_cnt   <= frame_done ? '0 : wr_cnt + 1'b1;
            end else if (idle_expired) begin
               idle_cnt  <= '0;
               wr_cnt    <= '0;
               timeout_o <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed self-checking bench for uart_frame_arbiter with NREQ=3, NBYTES=2
// and TIMEOUT_CYCLES=16; inputs change and outputs are sampled on the falling edge.
module tb_uart_frame_arbiter;

   logic        clk;
   logic        rst;
   logic [47:0] req_data;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [2:0]  req_mask;
   logic [15:0] frame_data;
   logic        frame_valid;
   logic [1:0]  frame_src;
   logic        uart_wr_en;
   logic        busy;
   logic        timeout;

   int errors;
   int checks;

   uart_frame_arbiter #(
      .NREQ(3),
      .NBYTES(2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_data_i    (req_data),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_mask_i    (req_mask),
      .frame_data_o  (frame_data),
      .frame_valid_o (frame_valid),
      .frame_src_o   (frame_src),
      .uart_wr_en_i  (uart_wr_en),
      .busy_o        (busy),
      .timeout_o     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] mask);
      req_valid = valid;
      req_mask  = mask;
      #1;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'h0);
      checkOutput({tag, "_fvalid"}, 32'(frame_valid), 32'h0);
      checkOutput({tag, "_fdata"}, 32'(frame_data), 32'h0);
      checkOutput({tag, "_fsrc"}, 32'(frame_src), 32'h0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_timeout"}, 32'(timeout), 32'h0);
   endtask

   // One full frame from the ARB cycle: grant, launch, then four back-to-back writes.
   task automatic runFrame(input string tag, input int exp_idx, input logic [15:0] exp_data);
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'(3'b001 << exp_idx));
      tick();
      checkOutput({tag, "_fvalid"}, 32'(frame_valid), 32'h1);
      checkOutput({tag, "_fsrc"}, 32'(frame_src), 32'(exp_idx));
      checkOutput({tag, "_fdata"}, 32'(frame_data), 32'(exp_data));
      tick();
      checkOutput({tag, "_fvalid_once"}, 32'(frame_valid), 32'h0);
      uart_wr_en = 1'b1;
      repeat (3) begin
         tick();
         checkOutput({tag, "_busy_wr"}, 32'(busy), 32'h1);
      end
      tick();
      uart_wr_en = 1'b0;
      #1;
      checkOutput({tag, "_done"}, 32'(busy), 32'h0);
   endtask

   initial begin
      int fair_order[5];
      int mask_order[3];
      fair_order = '{0, 1, 2, 0, 1};
      mask_order = '{0, 2, 0};
      errors     = 0;
      checks     = 0;
      rst        = 1'b1;
      req_data   = '0;
      req_valid  = 3'b000;
      req_mask   = 3'b111;
      uart_wr_en = 1'b0;
      tick();
      tick();
      checkReset("reset");
      rst = 1'b0;

      // Single request from requester 1
      req_data = {16'h3333, 16'hBEEF, 16'h1111};
      applyStimulus(3'b010, 3'b111);
      checkOutput("single_ready", 32'(req_ready), 32'h2);
      checkOutput("single_idle_busy", 32'(busy), 32'h0);
      tick();
      checkOutput("single_fvalid", 32'(frame_valid), 32'h1);
      checkOutput("single_fdata", 32'(frame_data), 32'hBEEF);
      checkOutput("single_fsrc", 32'(frame_src), 32'h1);
      checkOutput("single_ready_off", 32'(req_ready), 32'h0);
      tick();
      checkOutput("single_fvalid_once", 32'(frame_valid), 32'h0);
      uart_wr_en = 1'b1;
      repeat (3) begin
         tick();
         checkOutput("single_no_regrant", 32'(req_ready), 32'h0);
         checkOutput("single_busy", 32'(busy), 32'h1);
      end
      tick();
      uart_wr_en = 1'b0;
      #1;
      checkOutput("single_regrant", 32'(req_ready), 32'h2);
      checkOutput("single_hold_fdata", 32'(frame_data), 32'hBEEF);
      applyStimulus(3'b000, 3'b111);
      tick();
      checkOutput("single_stay_arb", 32'(busy), 32'h0);

      // Fairness with all requesters valid
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_data = {16'h3333, 16'h2222, 16'h1111};
      applyStimulus(3'b111, 3'b111);
      foreach (fair_order[i]) begin
         runFrame($sformatf("fair%0d", i), fair_order[i], 16'(16'h1111 * (fair_order[i] + 1)));
      end

      // Backpressure: writes spaced five cycles apart
      checkOutput("bp_ready", 32'(req_ready), 32'h4);
      tick();
      checkOutput("bp_fsrc", 32'(frame_src), 32'h2);
      tick();
      for (int p = 0; p < 4; p++) begin
         repeat (4) begin
            checkOutput("bp_busy", 32'(busy), 32'h1);
            checkOutput("bp_no_fvalid", 32'(frame_valid), 32'h0);
            tick();
         end
         uart_wr_en = 1'b1;
         tick();
         uart_wr_en = 1'b0;
      end
      #1;
      checkOutput("bp_done_busy", 32'(busy), 32'h0);
      checkOutput("bp_next_ready", 32'(req_ready), 32'h1);
      applyStimulus(3'b000, 3'b111);
      tick();

      // Timeout: no writes after launch
      applyStimulus(3'b100, 3'b111);
      checkOutput("to_ready", 32'(req_ready), 32'h4);
      tick();
      checkOutput("to_fvalid", 32'(frame_valid), 32'h1);
      applyStimulus(3'b000, 3'b111);
      tick();
      repeat (15) tick();
      checkOutput("to_still_busy", 32'(busy), 32'h1);
      checkOutput("to_not_yet", 32'(timeout), 32'h0);
      tick();
      checkOutput("to_back_arb", 32'(busy), 32'h0);
      checkOutput("to_flag", 32'(timeout), 32'h1);
      applyStimulus(3'b010, 3'b111);
      runFrame("to_after", 1, 16'h2222);
      checkOutput("to_sticky", 32'(timeout), 32'h1);
      applyStimulus(3'b000, 3'b111);

      // Mask excludes requester 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mask_to_cleared", 32'(timeout), 32'h0);
      applyStimulus(3'b111, 3'b101);
      foreach (mask_order[i]) begin
         runFrame($sformatf("mask%0d", i), mask_order[i], 16'(16'h1111 * (mask_order[i] + 1)));
      end

      // Reset in the middle of WAIT
      applyStimulus(3'b111, 3'b111);
      checkOutput("rw_ready", 32'(req_ready), 32'h2);
      tick();
      tick();
      uart_wr_en = 1'b1;
      tick();
      tick();
      uart_wr_en = 1'b0;
      checkOutput("rw_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("rw_ready_in_rst", 32'(req_ready), 32'h0);
      tick();
      checkReset("rw_reset");
      rst = 1'b0;
      #1;
      runFrame("rw_post", 0, 16'h1111);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
